// File: rtl/conv_pkg.sv
// Shared types and default sizing for the convolution input controller.
package conv_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    CONV = 1'b1
  } conv_state_t;

  localparam int unsigned DEF_F_MEM_SIZE       = 4;
  localparam int unsigned DEF_X_MEM_SIZE       = 8;
  localparam int unsigned DEF_F_MEM_ADDR_WIDTH = 2;
  localparam int unsigned DEF_X_MEM_ADDR_WIDTH = 3;
  localparam int unsigned FRAME_CNT_W          = 8;

endpackage

// File: rtl/load_cntr.sv
// Write-address counter with a sticky full flag for one sample memory.
// The counter wraps to 0 on the write that fills the memory, so it is
// already pointing at address 0 when the next frame starts loading.
module load_cntr #(
  parameter int unsigned SIZE   = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              clr_full,
  output logic [ADDR_W-1:0] cnt,
  output logic              full,
  output logic              last_wr_c
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE - 1);

  // Write landing on the final address fills the memory this edge.
  assign last_wr_c = wr_en && (cnt == LAST_ADDR);

  // Address advance, wrap on fill, flag clear on frame completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      full <= 1'b0;
    end else if (wr_en) begin
      if (cnt == LAST_ADDR) begin
        cnt  <= '0;
        full <= 1'b1;
      end else begin
        cnt <= cnt + ADDR_W'(1);
      end
    end else if (clr_full) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_conv_input.sv
// Input-side controller for a convolution engine: loads X samples and F
// coefficients into their memories, then hands off to the output controller.
// Optional macro CONV_FREUSE_EN: keep the filter loaded across frames so only
// X is reloaded after each convolution.
module ctrl_conv_input
  import conv_pkg::*;
#(
  parameter int unsigned F_MEM_SIZE       = DEF_F_MEM_SIZE,
  parameter int unsigned X_MEM_SIZE       = DEF_X_MEM_SIZE,
  parameter int unsigned X_MEM_ADDR_WIDTH = DEF_X_MEM_ADDR_WIDTH,
  parameter int unsigned F_MEM_ADDR_WIDTH = DEF_F_MEM_ADDR_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid_x,
  output logic                        s_ready_x,
  input  logic                        s_valid_f,
  output logic                        s_ready_f,
  output logic                        x_wr_en,
  output logic [X_MEM_ADDR_WIDTH-1:0] x_addr,
  output logic                        f_wr_en,
  output logic [F_MEM_ADDR_WIDTH-1:0] f_addr,
  output logic                        conv_start,
  input  logic                        conv_done,
  output logic [FRAME_CNT_W-1:0]      frame_cnt
);

  conv_state_t state;
  logic        x_full;
  logic        f_full;
  logic        x_last_wr;
  logic        f_last_wr;
  logic        frame_end;
  logic        f_clr;

  // Handshakes are open only while loading and only for a memory not yet full.
  assign s_ready_x = (state == LOAD) && !x_full;
  assign s_ready_f = (state == LOAD) && !f_full;
  assign x_wr_en   = s_valid_x && s_ready_x;
  assign f_wr_en   = s_valid_f && s_ready_f;

  assign frame_end = (state == CONV) && conv_done;

`ifdef CONV_FREUSE_EN
  assign f_clr = 1'b0;
`else
  assign f_clr = frame_end;
`endif

  // X sample memory address generator.
  load_cntr #(
    .SIZE   (X_MEM_SIZE),
    .ADDR_W (X_MEM_ADDR_WIDTH)
  ) u_x_cntr (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (x_wr_en),
    .clr_full  (frame_end),
    .cnt       (x_addr),
    .full      (x_full),
    .last_wr_c (x_last_wr)
  );

  // F coefficient memory address generator.
  load_cntr #(
    .SIZE   (F_MEM_SIZE),
    .ADDR_W (F_MEM_ADDR_WIDTH)
  ) u_f_cntr (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (f_wr_en),
    .clr_full  (f_clr),
    .cnt       (f_addr),
    .full      (f_full),
    .last_wr_c (f_last_wr)
  );

  // Load/convolve sequencing; conv_start mirrors the CONV state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      conv_start <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if ((x_full || x_last_wr) && (f_full || f_last_wr)) begin
            state      <= CONV;
            conv_start <= 1'b1;
          end
        end
        CONV: begin
          if (conv_done) begin
            state      <= LOAD;
            conv_start <= 1'b0;
            frame_cnt  <= frame_cnt + FRAME_CNT_W'(1);
          end
        end
        default: begin
          state      <= LOAD;
          conv_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_conv_input.sv
// Directed bench for ctrl_conv_input (default sizes: X=8, F=4).
module tb_ctrl_conv_input;

`ifdef CONV_FREUSE_EN
  localparam bit FREUSE = 1'b1;
`else
  localparam bit FREUSE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid_x;
  logic       s_ready_x;
  logic       s_valid_f;
  logic       s_ready_f;
  logic       x_wr_en;
  logic [2:0] x_addr;
  logic       f_wr_en;
  logic [1:0] f_addr;
  logic       conv_start;
  logic       conv_done;
  logic [7:0] frame_cnt;

  int checks   = 0;
  int errors   = 0;
  int x_writes = 0;
  int f_writes = 0;
  int exp_xa   = 0;
  int exp_fa   = 0;
  int x0;
  int f0;

  always #5 clk = ~clk;

  ctrl_conv_input dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid_x  (s_valid_x),
    .s_ready_x  (s_ready_x),
    .s_valid_f  (s_valid_f),
    .s_ready_f  (s_ready_f),
    .x_wr_en    (x_wr_en),
    .x_addr     (x_addr),
    .f_wr_en    (f_wr_en),
    .f_addr     (f_addr),
    .conv_start (conv_start),
    .conv_done  (conv_done),
    .frame_cnt  (frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, observe writes mid-cycle, return just after the edge.
  task automatic cycle(input logic vx, input logic vf, input logic done);
    s_valid_x = vx;
    s_valid_f = vf;
    conv_done = done;
    @(negedge clk);
    if (x_wr_en) begin
      check("x_addr", 32'(x_addr), 32'(exp_xa));
      exp_xa = (exp_xa + 1) % 8;
      x_writes++;
    end
    if (f_wr_en) begin
      check("f_addr", 32'(f_addr), 32'(exp_fa));
      exp_fa = (exp_fa + 1) % 4;
      f_writes++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    conv_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_conv_start", 32'(conv_start), 32'd0);
    check("rst_frame_cnt",  32'(frame_cnt),  32'd0);
    check("rst_ready_x",    32'(s_ready_x),  32'd1);
    check("rst_ready_f",    32'(s_ready_f),  32'd1);
    check("rst_x_wr_en",    32'(x_wr_en),    32'd0);
    check("rst_f_wr_en",    32'(f_wr_en),    32'd0);

    // Frame 1: both streams valid together
    x0 = x_writes; f0 = f_writes;
    repeat (7) cycle(1'b1, 1'b1, 1'b0);
    check("f1_start_early", 32'(conv_start), 32'd0);
    cycle(1'b1, 1'b1, 1'b0);
    check("f1_start",   32'(conv_start), 32'd1);
    check("f1_x_count", 32'(x_writes - x0), 32'd8);
    check("f1_f_count", 32'(f_writes - f0), 32'd4);

    // Valids held during CONV must not write
    x0 = x_writes; f0 = f_writes;
    repeat (10) cycle(1'b1, 1'b1, 1'b0);
    check("conv_x_count",  32'(x_writes - x0), 32'd0);
    check("conv_f_count",  32'(f_writes - f0), 32'd0);
    check("conv_ready_x",  32'(s_ready_x),     32'd0);
    check("conv_hold",     32'(conv_start),    32'd1);
    cycle(1'b0, 1'b0, 1'b1);
    check("f1_done_start", 32'(conv_start), 32'd0);
    check("f1_frame_cnt",  32'(frame_cnt),  32'd1);
    check("f1_ready_x",    32'(s_ready_x),  32'd1);
    check("f1_ready_f",    32'(s_ready_f),  32'(!FREUSE));

    // Frame 2: X alone, then F
    x0 = x_writes; f0 = f_writes;
    repeat (8) cycle(1'b1, 1'b0, 1'b0);
    check("f2_x_count",     32'(x_writes - x0), 32'd8);
    check("f2_start_x_only", 32'(conv_start),   32'(FREUSE));
    repeat (4) cycle(1'b0, 1'b1, 1'b0);
    check("f2_f_count", 32'(f_writes - f0), FREUSE ? 32'd0 : 32'd4);
    check("f2_start",   32'(conv_start),    32'd1);
    cycle(1'b0, 1'b0, 1'b1);
    check("f2_frame_cnt", 32'(frame_cnt), 32'd2);

    // Frame 3: F first, then X with toggling valid
    f0 = f_writes;
    repeat (4) cycle(1'b0, 1'b1, 1'b0);
    check("f3_f_count",      32'(f_writes - f0), FREUSE ? 32'd0 : 32'd4);
    check("f3_start_f_only", 32'(conv_start),    32'd0);
    x0 = x_writes; f0 = f_writes;
    for (int i = 0; i < 16; i++) cycle((i % 2) == 0, 1'b1, 1'b0);
    check("f3_x_count",  32'(x_writes - x0), 32'd8);
    check("f3_no_f_wr",  32'(f_writes - f0), 32'd0);
    check("f3_start",    32'(conv_start),    32'd1);
    cycle(1'b0, 1'b0, 1'b1);
    check("f3_frame_cnt", 32'(frame_cnt), 32'd3);

    // Frame 4: conv_done during LOAD is ignored
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check("load_done_frame_cnt", 32'(frame_cnt),  32'd3);
    check("load_done_start",     32'(conv_start), 32'd0);
    check("load_done_ready_x",   32'(s_ready_x),  32'd1);
    s_valid_x = 1'b1;
    #1;
    check("load_done_x_addr", 32'(x_addr),  32'd3);
    check("load_done_x_wr",   32'(x_wr_en), 32'd1);
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 1'b1, 1'b0);
    check("f4_start", 32'(conv_start), 32'd1);

    // Reset during CONV wins over conv_done and abandons the frame
    reset = 1'b1;
    cycle(1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    exp_xa = 0; exp_fa = 0;
    check("rst_conv_start2", 32'(conv_start), 32'd0);
    check("rst_frame_cnt2",  32'(frame_cnt),  32'd0);
    check("rst_ready_x2",    32'(s_ready_x),  32'd1);
    check("rst_ready_f2",    32'(s_ready_f),  32'd1);
    s_valid_x = 1'b1;
    s_valid_f = 1'b0;
    conv_done = 1'b0;
    #1;
    check("rst_x_addr", 32'(x_addr), 32'd0);
    cycle(1'b1, 1'b0, 1'b0);

    // Reset mid-load restarts addressing
    repeat (2) cycle(1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    exp_xa = 0;
    s_valid_x = 1'b1;
    #1;
    check("midload_rst_x_addr", 32'(x_addr), 32'd0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_conv_input.md
CTRL_CONV_INPUT -- requirements
Module: ctrl_conv_input

Interface
REQ-001 SHALL have parameter F_MEM_SIZE, default 4, number of filter coefficients.
REQ-002 SHALL have parameter X_MEM_SIZE, default 8, number of input samples per frame.
REQ-003 SHALL have parameter X_MEM_ADDR_WIDTH, default 3, X memory address width.
REQ-004 SHALL have parameter F_MEM_ADDR_WIDTH, default 2, F memory address width.
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have port s_valid_x, input, 1, upstream X sample valid.
REQ-008 SHALL have port s_ready_x, output, 1, X sample accepted when high with s_valid_x.
REQ-009 SHALL have port s_valid_f, input, 1, upstream F coefficient valid.
REQ-010 SHALL have port s_ready_f, output, 1, F coefficient accepted when high with s_valid_f.
REQ-011 SHALL have port x_wr_en, output, 1, X memory write strobe.
REQ-012 SHALL have port x_addr, output, X_MEM_ADDR_WIDTH, X memory write address.
REQ-013 SHALL have port f_wr_en, output, 1, F memory write strobe.
REQ-014 SHALL have port f_addr, output, F_MEM_ADDR_WIDTH, F memory write address.
REQ-015 SHALL have port conv_start, output, 1, level request to the output controller to run convolution.
REQ-016 SHALL have port conv_done, input, 1, one-cycle pulse from the output controller, frame complete.
REQ-017 SHALL have port frame_cnt, output, 8, completed-frame count, wraps 255->0.

Function
REQ-018 SHALL implement FSM states LOAD and CONV; reset state LOAD.
REQ-019 In LOAD: s_ready_x = !x_full; s_ready_f = !f_full; in CONV both ready outputs SHALL be 0 (combinational from registered state/flags).
REQ-020 x_wr_en SHALL equal s_valid_x & s_ready_x; x_addr SHALL equal x_cnt; f path identical with f_cnt.
REQ-021 Each write SHALL increment its counter; a write at address SIZE-1 SHALL set the full flag and clear the counter to 0 on the same edge.
REQ-022 X and F loads SHALL proceed independently and concurrently, including simultaneous writes.
REQ-023 LOAD->CONV SHALL occur on the edge at which both flags are, or become, set; last write in cycle N gives conv_start=1 in cycle N+1.
REQ-024 conv_start SHALL be a registered output, high exactly while in CONV.
REQ-025 In CONV, conv_done=1 SHALL cause CONV->LOAD, clear x_full (and f_full per REQ-032), and increment frame_cnt; conv_start=0 on the next cycle.
REQ-026 conv_done while in LOAD SHALL be ignored (no state, flag or frame_cnt change).
REQ-027 s_valid_x/s_valid_f during CONV SHALL produce no write and no counter change.
REQ-028 Counters SHALL never exceed SIZE-1; X_MEM_SIZE <= 2**X_MEM_ADDR_WIDTH and F_MEM_SIZE <= 2**F_MEM_ADDR_WIDTH are required.

Reset
REQ-029 On reset: state LOAD, x_cnt=0, f_cnt=0, x_full=0, f_full=0, conv_start=0, frame_cnt=0; hence s_ready_x=1, s_ready_f=1, x_wr_en=0, f_wr_en=0.
REQ-030 Reset in any state, mid-load or mid-convolution, SHALL abandon the frame and take precedence over all other events.

Configuration
REQ-031 Macro CONV_FREUSE_EN SHALL select filter reuse.
REQ-032 With CONV_FREUSE_EN defined, f_full SHALL be cleared only by reset, so F loads once and later frames reload only X; without it, conv_done clears f_full as well as x_full.

Structure
REQ-033 Package conv_pkg SHALL hold the state enum (LOAD, CONV) and default size/width constants.
REQ-034 One sub-module, load_cntr (address counter plus full flag, parameterised size/width), SHALL be instantiated twice, for X and F.

Verification
REQ-035 Reset, then s_valid_x and s_valid_f held high -> writes x_addr 0..7 and f_addr 0..3; conv_start=1 in the cycle after x_addr=7 write.
REQ-036 Feed F fully, then X with valid toggling 1,0,1,0 -> only 8 x_wr_en pulses, addresses contiguous 0..7, no F write after f_addr=3.
REQ-037 In CONV with s_valid_x=1 for 10 cycles, then conv_done pulse -> zero writes while in CONV; conv_start=0 next cycle, frame_cnt=1, s_ready_x=1.
REQ-038 conv_done pulse while in LOAD after 3 X writes -> no change: x_addr continues at 3, frame_cnt=0.
REQ-039 Reset asserted in CONV after 2 frames -> conv_start=0, frame_cnt=0, next X write at x_addr=0.
REQ-040 CONV_FREUSE_EN defined, 2 frames -> F writes only in frame 1; frame 2 reaches conv_start after 8 X writes alone; undefined -> frame 2 waits for 4 F writes.
